code_event_logger: RTL and testbench
====================================

// Module: code_event_logger
// PURPOSE
//  Downstream consumer of the serial pattern-detector FSM. Samples its 3-bit
//  code output every clock and timestamps each legal non-zero code. Events go
//  into a first-word-fall-through FIFO drained over a valid/ready interface.
//  Keeps per-code saturating event counters and sticky error flags for
//  software and debug readout.
// PARAMETERS
//  DEPTH  8   FIFO entries; power of two, >= 2
//  TS_W   16  timestamp width; free-running cycle counter, wraps mod 2^TS_W
//  CNT_W  8   width of each per-code counter; saturates at all-ones
// PORTS
//  Clk         in   1          clock; all logic on posedge
//  Rst_n       in   1          asynchronous, active-low reset
//  code        in   3          detector output, sampled every cycle
//  clr         in   1          synchronous clear of counters and sticky flags
//  out_valid   out  1          FIFO non-empty
//  out_ready   in   1          consumer accepts head entry when out_valid=1
//  out_code    out  3          head-entry code; 0 when empty
//  out_ts      out  TS_W       head-entry timestamp; 0 when empty
//  cnt_p1      out  CNT_W      count of code 3'b001
//  cnt_p2      out  CNT_W      count of code 3'b010
//  cnt_p3      out  CNT_W      count of code 3'b011
//  cnt_p7      out  CNT_W      count of code 3'b111
//  overflow    out  1          sticky: a legal event was dropped because the FIFO was full
//  illegal     out  1          sticky: code was 3'b100, 3'b101 or 3'b110
//  level       out  log2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset:
//   - Rst_n=0 asynchronously clears FIFO pointers, level, ts counter,
//     all counters, overflow and illegal.
//   - out_valid=0; out_code=0; out_ts=0.
//  Timestamp:
//   - ts increments by 1 every cycle out of reset; wraps from 2^TS_W-1 to 0.
//   - An event captured in cycle N stores the ts value present in cycle N.
//  Event classes:
//   - Legal: 001, 010, 011, 111.
//   - Idle: 000; no action.
//   - Illegal: 100, 101, 110; sets illegal, not pushed, not counted.
//   - Every cycle with a legal code is one event; no edge detection.
//     Back-to-back equal codes are two events.
//  Push:
//   - Legal event and (level<DEPTH, or level==DEPTH with pop in the same
//     cycle) -> entry {code, ts} written.
//   - Otherwise the event is dropped and overflow is set.
//  Pop:
//   - out_valid && out_ready -> head advances.
//   - Simultaneous push and pop: level unchanged.
//   - out_ready while empty: no effect.
//  FWFT latency:
//   - An event sampled at edge N makes out_valid=1 with that head after edge N.
//   - 1-cycle latency code->out_valid when the FIFO was empty.
//   - A popped entry is replaced by the next head on the following cycle.
//  Pointers: log2(DEPTH) bits, wrap naturally. level distinguishes full from empty.
//  Counters:
//   - Matching counter increments on every legal event, including dropped ones.
//   - Saturates at 2^CNT_W-1 and never wraps.
//  clr:
//   - Zeroes all cnt_* plus overflow and illegal at the next edge.
//   - Clear wins over a same-cycle increment or flag set.
//   - FIFO, level and ts are unaffected; a same-cycle legal event is still pushed.
//  Outputs: all registered or driven directly from registered FIFO state; no combinational path code->outputs.
//  Reset mid-operation: Rst_n assertion discards FIFO contents immediately; no partial pop is visible.
// STRUCTURE
//  Package fsm_pkg:
//   - localparams CODE_IDLE=3'b000, CODE_P1=3'b001, CODE_P2=3'b010,
//     CODE_P3=3'b011, CODE_P7=3'b111.
//   - Function is_legal_code(code).
//  Sub-module sync_fifo #(WIDTH=3+TS_W, DEPTH):
//   - Ports: Clk, Rst_n, push, din, pop, dout, full, empty, level.
//   - Dual-pointer FWFT storage array.
//   - Top level keeps classification, ts counter, counters, sticky flags and handshake gating.
// TESTING
//  - Reset: Rst_n=0 mid-stream with 3 entries queued -> out_valid=0, level=0,
//    all counts 0, out_code=0, out_ts=0 in the same cycle.
//  - Single event: code=001 for 1 cycle at ts=5, out_ready=0 -> next cycle
//    out_valid=1, out_code=001, out_ts=5, cnt_p1=1. Pop -> out_valid=0.
//  - Fill/overflow (DEPTH=8): 10 legal events, out_ready=0 -> level=8, overflow=1,
//    counters total 10. Drain yields the first 8 in order with increasing ts.
//  - Full + simultaneous push/pop: level=8, code=111, out_ready=1 -> level stays 8,
//    overflow stays 0, the new entry is last to drain.
//  - Illegal/saturation: code=101 -> illegal=1, level unchanged. 300 events of 010
//    with CNT_W=8 -> cnt_p2=255. clr -> cnt_p2=0, illegal=0.
//  - ts wrap (TS_W=4): event at cycle 15 then at cycle 16 -> out_ts 15 then 0.

Source files
------------

// File: rtl/code_event_logger_pkg.sv
// Purpose: shared code constants and classification helper for the
//          pattern-detector event logger.
// Contents:
//   CODE_IDLE, CODE_P1, CODE_P2, CODE_P3, CODE_P7 : detector code values
//   is_legal_code(code)                          : 1 for codes that are logged
package fsm_pkg;

  localparam logic [2:0] CODE_IDLE = 3'b000;
  localparam logic [2:0] CODE_P1   = 3'b001;
  localparam logic [2:0] CODE_P2   = 3'b010;
  localparam logic [2:0] CODE_P3   = 3'b011;
  localparam logic [2:0] CODE_P7   = 3'b111;

  function automatic logic is_legal_code(input logic [2:0] code);
    return (code == CODE_P1) || (code == CODE_P2) ||
           (code == CODE_P3) || (code == CODE_P7);
  endfunction

endpackage

// File: rtl/code_event_logger_fifo.sv
// Purpose: first-word-fall-through FIFO. The head entry is visible on dout
//          whenever the FIFO is non-empty; dout is forced to 0 when empty.
// Ports:
//   Clk, Rst_n : clock, asynchronous active-low reset (clears pointers/level)
//   push, din  : write request and data; accepted when not full, or when full
//                and a pop happens in the same cycle
//   pop        : advance head; ignored while empty
//   dout       : head entry (0 when empty)
//   full/empty : occupancy flags
//   level      : current occupancy, 0..DEPTH
module sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   level
);

  localparam logic [PTR_W:0] FULL_LVL = DEPTH[PTR_W:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Storage needs no reset: the level gate below hides stale contents.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/code_event_logger.sv
// Purpose: samples the detector's 3-bit code every clock, timestamps each
//          legal non-zero code into a FWFT FIFO, keeps saturating per-code
//          counters and sticky overflow/illegal flags.
// Ports:
//   Clk, Rst_n           : clock, asynchronous active-low reset
//   code                 : detector output, sampled every cycle
//   clr                  : synchronous clear of counters and sticky flags
//   out_valid/out_ready  : drain handshake for the FIFO head
//   out_code, out_ts     : head entry (0 when empty)
//   cnt_p1..cnt_p7       : saturating event counts for codes 001/010/011/111
//   overflow             : sticky, legal event dropped on a full FIFO
//   illegal              : sticky, code 100/101/110 seen
//   level                : FIFO occupancy
module code_event_logger
  import fsm_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16,
  parameter int CNT_W = 8,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [2:0]       code,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_code,
  output logic [TS_W-1:0]  out_ts,
  output logic [CNT_W-1:0] cnt_p1,
  output logic [CNT_W-1:0] cnt_p2,
  output logic [CNT_W-1:0] cnt_p3,
  output logic [CNT_W-1:0] cnt_p7,
  output logic             overflow,
  output logic             illegal,
  output logic [LVL_W-1:0] level
);

  // Handshake: the head entry transfers on any rising edge where
  // out_valid && out_ready are both 1. out_valid never depends on out_ready,
  // and out_ready while empty is ignored.

  logic [TS_W-1:0]           ts;
  logic                      legal;
  logic                      bad_code;
  logic                      pop;
  logic                      full;
  logic                      empty;
  logic                      dropped;
  logic [3:0]                hit;
  logic [3:0][CNT_W-1:0]     cnt;

  assign legal    = is_legal_code(code);
  assign bad_code = (code != CODE_IDLE) && !legal;
  assign out_valid = !empty;
  assign pop      = out_valid && out_ready;
  assign dropped  = legal && full && !pop;

  // Each legal code hits exactly one counter, dropped events included.
  assign hit = {code == CODE_P7, code == CODE_P3, code == CODE_P2, code == CODE_P1};

  sync_fifo #(
    .WIDTH (3 + TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .push  (legal),
    .din   ({code, ts}),
    .pop   (pop),
    .dout  ({out_code, out_ts}),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

  // clr takes priority over any same-cycle increment or flag set.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt      <= '0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (clr) begin
      cnt      <= '0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (hit[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
      if (dropped)  overflow <= 1'b1;
      if (bad_code) illegal  <= 1'b1;
    end
  end

  assign cnt_p1 = cnt[0];
  assign cnt_p2 = cnt[1];
  assign cnt_p3 = cnt[2];
  assign cnt_p7 = cnt[3];

endmodule

// File: tb/tb_code_event_logger.sv
module tb_code_event_logger;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // edges since reset release == DUT timestamp value seen at a negedge
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- main DUT (defaults) ----------------
  logic [2:0]  code;
  logic        clr;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_code;
  logic [15:0] out_ts;
  logic [7:0]  cnt_p1, cnt_p2, cnt_p3, cnt_p7;
  logic        overflow, illegal;
  logic [3:0]  level;

  code_event_logger #(.DEPTH(8), .TS_W(16), .CNT_W(8)) dut (
    .Clk(clk), .Rst_n(rst_n), .code(code), .clr(clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_ts(out_ts), .cnt_p1(cnt_p1), .cnt_p2(cnt_p2), .cnt_p3(cnt_p3),
    .cnt_p7(cnt_p7), .overflow(overflow), .illegal(illegal), .level(level)
  );

  // ---------------- narrow-timestamp DUT for wrap ----------------
  logic [2:0] code_w;
  logic       out_valid_w;
  logic       out_ready_w;
  logic [2:0] out_code_w;
  logic [3:0] out_ts_w;
  logic [7:0] cnt_p1_w, cnt_p2_w, cnt_p3_w, cnt_p7_w;
  logic       overflow_w, illegal_w;
  logic [3:0] level_w;

  code_event_logger #(.DEPTH(8), .TS_W(4), .CNT_W(8)) dut_w (
    .Clk(clk), .Rst_n(rst_n), .code(code_w), .clr(clr),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .out_code(out_code_w),
    .out_ts(out_ts_w), .cnt_p1(cnt_p1_w), .cnt_p2(cnt_p2_w), .cnt_p3(cnt_p3_w),
    .cnt_p7(cnt_p7_w), .overflow(overflow_w), .illegal(illegal_w), .level(level_w)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int errors  = 0;
  logic [18:0] exp_q[$];
  logic [2:0]  pat[10] = '{3'b001, 3'b010, 3'b011, 3'b111, 3'b001,
                           3'b010, 3'b011, 3'b111, 3'b001, 3'b010};

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; code = 3'd0; code_w = 3'd0; clr = 1'b0;
    out_ready = 1'b0; out_ready_w = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc != n && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    vectors++;
    if (cyc != n) begin
      errors++;
      $display("FAIL wait_cyc: got cycle %0d expected %0d", cyc, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || level !== 4'd0 || out_code !== 3'd0 || out_ts !== 16'd0) begin
      errors++;
      $display("FAIL reset_fifo: valid=%b level=%0d code=%0d ts=%0d expected 0/0/0/0",
               out_valid, level, out_code, out_ts);
    end
    vectors++;
    if ({cnt_p1, cnt_p2, cnt_p3, cnt_p7, overflow, illegal} !== 34'd0) begin
      errors++;
      $display("FAIL reset_counts: p1=%0d p2=%0d p3=%0d p7=%0d ovf=%b ill=%b expected all 0",
               cnt_p1, cnt_p2, cnt_p3, cnt_p7, overflow, illegal);
    end
  endtask

  task automatic test_single();
    do_reset();
    wait_cyc(5);
    code = 3'b001;
    @(negedge clk);
    code = 3'b000;
    vectors++;
    if (out_valid !== 1'b1 || out_code !== 3'b001 || out_ts !== 16'd5 || cnt_p1 !== 8'd1) begin
      errors++;
      $display("FAIL single_event: valid=%b code=%0d ts=%0d p1=%0d expected 1/1/5/1",
               out_valid, out_code, out_ts, cnt_p1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || level !== 4'd0 || out_code !== 3'd0) begin
      errors++;
      $display("FAIL single_pop: valid=%b level=%0d code=%0d expected 0/0/0",
               out_valid, level, out_code);
    end
    // ready while empty must not disturb anything
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL empty_ready: valid=%b level=%0d expected 0/0", out_valid, level);
    end
  endtask

  task automatic drain_and_check(input string name);
    int n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || {out_code, out_ts} !== exp_q[0]) begin
        errors++;
        $display("FAIL %s_drain%0d: valid=%b code=%0d ts=%0d expected code=%0d ts=%0d",
                 name, i, out_valid, out_code, out_ts, exp_q[0][18:16], exp_q[0][15:0]);
      end
      void'(exp_q.pop_front());
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL %s_empty: valid=%b level=%0d expected 0/0", name, out_valid, level);
    end
  endtask

  task automatic test_fill_overflow();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      code = pat[i];
      if (i < 8) exp_q.push_back({pat[i], 16'(cyc)});
      @(negedge clk);
    end
    code = 3'd0;
    vectors++;
    if (level !== 4'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fill_level: level=%0d ovf=%b expected 8/1", level, overflow);
    end
    vectors++;
    if (cnt_p1 !== 8'd3 || cnt_p2 !== 8'd3 || cnt_p3 !== 8'd2 || cnt_p7 !== 8'd2) begin
      errors++;
      $display("FAIL fill_counts: p1=%0d p2=%0d p3=%0d p7=%0d expected 3/3/2/2",
               cnt_p1, cnt_p2, cnt_p3, cnt_p7);
    end
    drain_and_check("fill");
  endtask

  task automatic test_full_push_pop();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      code = pat[i];
      exp_q.push_back({pat[i], 16'(cyc)});
      @(negedge clk);
    end
    vectors++;
    if (level !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fpp_full: level=%0d ovf=%b expected 8/0", level, overflow);
    end
    vectors++;
    if ({out_code, out_ts} !== exp_q[0]) begin
      errors++;
      $display("FAIL fpp_head: code=%0d ts=%0d expected code=%0d ts=%0d",
               out_code, out_ts, exp_q[0][18:16], exp_q[0][15:0]);
    end
    code = 3'b111;
    out_ready = 1'b1;
    void'(exp_q.pop_front());
    exp_q.push_back({3'b111, 16'(cyc)});
    @(negedge clk);
    code = 3'd0;
    out_ready = 1'b0;
    vectors++;
    if (level !== 4'd8 || overflow !== 1'b0 || cnt_p7 !== 8'd3) begin
      errors++;
      $display("FAIL fpp_level: level=%0d ovf=%b p7=%0d expected 8/0/3", level, overflow, cnt_p7);
    end
    drain_and_check("fpp");
  endtask

  task automatic test_illegal_sat();
    do_reset();
    @(negedge clk);
    code = 3'b101;
    @(negedge clk);
    code = 3'b000;
    vectors++;
    if (illegal !== 1'b1 || level !== 4'd0 || out_valid !== 1'b0 ||
        {cnt_p1, cnt_p2, cnt_p3, cnt_p7} !== 32'd0) begin
      errors++;
      $display("FAIL illegal_flag: ill=%b level=%0d valid=%b counts=%h expected 1/0/0/0",
               illegal, level, out_valid, {cnt_p1, cnt_p2, cnt_p3, cnt_p7});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      code = 3'b010;
      @(negedge clk);
    end
    code = 3'b000;
    out_ready = 1'b0;
    vectors++;
    if (cnt_p2 !== 8'd255 || level !== 4'd1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL saturate: p2=%0d level=%0d ovf=%b expected 255/1/0", cnt_p2, level, overflow);
    end
    // clear together with a legal event: counter cleared, event still queued
    clr = 1'b1;
    code = 3'b010;
    @(negedge clk);
    code = 3'b110;
    @(negedge clk);
    clr = 1'b0;
    code = 3'b000;
    vectors++;
    if (cnt_p2 !== 8'd0 || illegal !== 1'b0 || overflow !== 1'b0 || level !== 4'd2) begin
      errors++;
      $display("FAIL clr: p2=%0d ill=%b ovf=%b level=%0d expected 0/0/0/2",
               cnt_p2, illegal, overflow, level);
    end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    wait_cyc(15);
    code_w = 3'b001;
    @(negedge clk);
    code_w = 3'b011;
    @(negedge clk);
    code_w = 3'b000;
    vectors++;
    if (level_w !== 4'd2 || out_code_w !== 3'b001 || out_ts_w !== 4'd15) begin
      errors++;
      $display("FAIL wrap_first: level=%0d code=%0d ts=%0d expected 2/1/15",
               level_w, out_code_w, out_ts_w);
    end
    out_ready_w = 1'b1;
    @(negedge clk);
    out_ready_w = 1'b0;
    vectors++;
    if (out_valid_w !== 1'b1 || out_code_w !== 3'b011 || out_ts_w !== 4'd0) begin
      errors++;
      $display("FAIL wrap_second: valid=%b code=%0d ts=%0d expected 1/3/0",
               out_valid_w, out_code_w, out_ts_w);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      code = pat[i];
      @(negedge clk);
    end
    code = 3'b101;
    vectors++;
    if (level !== 4'd3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: level=%0d valid=%b expected 3/1", level, out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || level !== 4'd0 || out_code !== 3'd0 || out_ts !== 16'd0 ||
        {cnt_p1, cnt_p2, cnt_p3, cnt_p7, overflow, illegal} !== 34'd0) begin
      errors++;
      $display("FAIL mid_reset: valid=%b level=%0d code=%0d ts=%0d p1=%0d p2=%0d p3=%0d expected all 0",
               out_valid, level, out_code, out_ts, cnt_p1, cnt_p2, cnt_p3);
    end
    code = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    code = 3'd0; code_w = 3'd0; clr = 1'b0; out_ready = 1'b0; out_ready_w = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_illegal_sat();
    test_ts_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
